data_mem_ctrl: RTL and testbench

//   Byte-addressable big-endian data memory for the RV32 core, behind a valid/ready request/response handshake.

---
 rtl/data_mem_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_ctrl
// Description : Byte-addressable, big-endian data memory for the RV32 MEM
//               stage, behind a valid/ready request/response handshake.
//               Handles SB/SH/SW stores with per-byte enables and
//               LB/LH/LW/LBU/LHU loads with sign/zero extension.
//               Read latency is programmable (READ_LATENCY, 1..4), and
//               misaligned or illegal-funct3 accesses return ERR=1.
// Config      : `define DMEM_BOUNDS_CHECK_EN to flag addresses at or beyond
//               DEPTH_WORDS*4 as errors. Without it the access wraps modulo
//               the byte space.
// Ports       : clk         rising-edge clock
//               rst_n       asynchronous active-low reset
//               req_valid   request present
//               req_ready   request can be accepted (IDLE only)
//               req_we      1 = store, 0 = load
//               funct3      RV32 access size/sign code
//               address     byte address
//               write_data  store data (low bytes used for SB/SH)
//               rsp_valid   response valid, held until rsp_ready
//               rsp_ready   consumer accepts the response
//               read_data   extended load result (0 for stores/errors)
//               err         response carries an error
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       read_data,
    output logic              err
);

    localparam int         c_IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [1:0] c_LOAD_CNT = 2'(READ_LATENCY - 1);

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Word-organised storage; contents are deliberately not reset.
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [1:0]         r_cnt;
    logic               r_err;
    logic               r_load_ok;
    logic [2:0]         r_funct3;
    logic [1:0]         r_off;
    logic [31:0]        r_word;

    logic               w_accept;
    logic [1:0]         w_off;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_is_b;
    logic               w_is_h;
    logic               w_is_w;
    logic               w_misaligned;
    logic               w_illegal;
    logic               w_oob;
    logic               w_err;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic               w_unused_addr;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_off = address[1:0];
    assign w_idx = address[c_IDX_W+1:2];

    // Upper address bits only matter for the optional bounds check.
    assign w_unused_addr = ^address;

    always_comb begin
        w_is_b = 1'b0;
        w_is_h = 1'b0;
        w_is_w = 1'b0;
        case (funct3)
            c_F3_B, c_F3_BU: w_is_b = 1'b1;
            c_F3_H, c_F3_HU: w_is_h = 1'b1;
            c_F3_W:          w_is_w = 1'b1;
            default:         ;
        endcase
    end

    assign w_misaligned = (w_is_h && w_off[0]) || (w_is_w && (w_off != 2'b00));
    assign w_illegal    = !(w_is_b || w_is_h || w_is_w);

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic [ADDR_W:0] c_BYTE_SPACE = (ADDR_W+1)'(DEPTH_WORDS * 4);
    assign w_oob = ({1'b0, address} >= c_BYTE_SPACE);
`else
    assign w_oob = 1'b0;
`endif

    assign w_err = w_misaligned || w_illegal || w_oob;

    // Byte enables: w_be[b] covers word bits [8b+7:8b], so byte offset k
    // (big-endian lane k, bits [31-8k -: 8]) is w_be[3-k]. Store data is
    // replicated across lanes so the enabled lanes see the right bytes.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = write_data;
        if (w_is_b) begin
            w_be    = 4'b1000 >> w_off;
            w_wdata = {4{write_data[7:0]}};
        end else if (w_is_h) begin
            w_be    = 4'b1100 >> w_off;
            w_wdata = {2{write_data[15:0]}};
        end else if (w_is_w) begin
            w_be    = 4'b1111;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        // Ready is masked while reset is asserted so no store can slip
        // into the array during reset.
        req_ready   = (r_state == S_IDLE) && rst_n;
        rsp_valid   = (r_state == S_RESP);
        w_accept    = req_valid && req_ready;
        case (r_state)
            S_IDLE: if (w_accept)          w_state_nxt = S_WAIT;
            S_WAIT: if (r_cnt == 2'd0)     w_state_nxt = S_RESP;
            S_RESP: if (rsp_ready)         w_state_nxt = S_IDLE;
            default:                       w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Captured request attributes and latency counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 2'd0;
            r_err     <= 1'b0;
            r_load_ok <= 1'b0;
            r_funct3  <= 3'b000;
            r_off     <= 2'b00;
        end else if (w_accept) begin
            r_cnt     <= req_we ? 2'd0 : c_LOAD_CNT;
            r_err     <= w_err;
            r_load_ok <= !req_we && !w_err;
            r_funct3  <= funct3;
            r_off     <= w_off;
        end else if ((r_state == S_WAIT) && (r_cnt != 2'd0)) begin
            r_cnt     <= r_cnt - 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // RAM array: write and read both happen at the accept edge. The read
    // returns the pre-write contents, which only matters for stores whose
    // read result is discarded anyway.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_word <= r_mem[w_idx];
            if (req_we && !w_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) begin
                        r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load extraction and extension. Driven purely from values captured
    // at accept, so the response is stable for as long as it is held.
    // ------------------------------------------------------------------
    always_comb begin
        w_byte = r_word[31:24];
        case (r_off)
            2'd0:    w_byte = r_word[31:24];
            2'd1:    w_byte = r_word[23:16];
            2'd2:    w_byte = r_word[15:8];
            default: w_byte = r_word[7:0];
        endcase
        w_half = r_off[1] ? r_word[15:0] : r_word[31:16];

        read_data = 32'h0000_0000;
        if (r_load_ok) begin
            case (r_funct3)
                c_F3_B:  read_data = {{24{w_byte[7]}}, w_byte};
                c_F3_BU: read_data = {24'h00_0000, w_byte};
                c_F3_H:  read_data = {{16{w_half[15]}}, w_half};
                c_F3_HU: read_data = {16'h0000, w_half};
                c_F3_W:  read_data = r_word;
                default: read_data = 32'h0000_0000;
            endcase
        end
    end

    assign err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Self-checking bench for data_mem_ctrl. Two instances
//               (READ_LATENCY 1 and 3) are driven against a byte-array
//               big-endian memory model; the model predicts handshake
//               timing and response contents every cycle, and directed
//               literal checks pin the model for the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

    localparam int DEPTH = 64;
    localparam int BYTES = DEPTH * 4;
    localparam int NI    = 2;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic        T6_ERR  = 1'b1;
    localparam logic [31:0] T6_WORD = 32'h01FE5AC3;
`else
    localparam logic        T6_ERR  = 1'b0;
    localparam logic [31:0] T6_WORD = 32'hCAFEF00D;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid  [NI];
    logic        req_ready  [NI];
    logic        req_we     [NI];
    logic [2:0]  funct3     [NI];
    logic [31:0] address    [NI];
    logic [31:0] write_data [NI];
    logic        rsp_valid  [NI];
    logic        rsp_ready  [NI];
    logic [31:0] read_data  [NI];
    logic        err_o      [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        data_mem_ctrl #(
            .DEPTH_WORDS  (DEPTH),
            .READ_LATENCY ((g == 0) ? 1 : 3),
            .ADDR_W       (32)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_we     (req_we[g]),
            .funct3     (funct3[g]),
            .address    (address[g]),
            .write_data (write_data[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .read_data  (read_data[g]),
            .err        (err_o[g])
        );
    end

    // ------------------------------------------------------------------
    // Reference model: a plain byte array per instance, plus the cycle
    // number of the accepted request and its expected response.
    // ------------------------------------------------------------------
    logic [7:0]  mem_m  [NI][BYTES];
    bit          m_pend [NI];
    int          m_acc  [NI];
    int          m_lat  [NI];
    logic [31:0] m_data [NI];
    logic        m_err  [NI];
    int          cyc = 0;
    bit          hold_low [NI];

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input int i,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, expected %h at cycle %0d", name, i, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] fill_val(input int w);
        logic [7:0] lo;
        lo = 8'(w);
        return {lo, ~lo, 8'h5A, 8'hC3};
    endfunction

    function automatic void model_access(input int i, input logic we, input logic [2:0] f3,
                                         input logic [31:0] addr, input logic [31:0] wd,
                                         output logic [31:0] data, output logic e);
        int          size;
        int unsigned a;
        bit          oob;
        a   = addr % BYTES;
        oob = 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
        oob = (addr >= BYTES);
`endif
        case (f3)
            F_B, F_BU: size = 1;
            F_H, F_HU: size = 2;
            F_W:       size = 4;
            default:   size = 0;
        endcase
        data = 32'h0;
        e    = 1'b0;
        if (size == 0 || oob || (a % size) != 0) begin
            e = 1'b1;
            return;
        end
        if (we) begin
            for (int b = 0; b < size; b++) mem_m[i][a+b] = wd[8*(size-1-b) +: 8];
        end else begin
            for (int b = 0; b < size; b++) data = (data << 8) | 32'(mem_m[i][a+b]);
            if (!f3[2] && size == 1 && data[7])  data = data | 32'hFFFFFF00;
            if (!f3[2] && size == 2 && data[15]) data = data | 32'hFFFF0000;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) m_pend[i] = 1'b0;
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (m_pend[i]) begin
                    if (cyc >= m_acc[i] + m_lat[i] && rsp_ready[i]) m_pend[i] = 1'b0;
                end else if (req_valid[i]) begin
                    model_access(i, req_we[i], funct3[i], address[i], write_data[i],
                                 m_data[i], m_err[i]);
                    m_lat[i]  = req_we[i] ? 1 : ((i == 0) ? 1 : 3);
                    m_acc[i]  = cyc + 1;
                    m_pend[i] = 1'b1;
                end
            end
            cyc++;
        end
    end

    // Compare process: every cycle, handshake outputs and (while a
    // response is due) its contents.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                chk("rsp_valid_in_reset", i, 32'(rsp_valid[i]), 32'd0);
            end else begin
                bit ev;
                ev = m_pend[i] && (cyc >= m_acc[i] + m_lat[i]);
                chk("req_ready", i, 32'(req_ready[i]), 32'(!m_pend[i]));
                chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(ev));
                if (ev) begin
                    chk("read_data", i, read_data[i], m_data[i]);
                    chk("err", i, 32'(err_o[i]), 32'(m_err[i]));
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NI; i++)
            rsp_ready[i] = hold_low[i] ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // ------------------------------------------------------------------
    // Stimulus tasks (all entered and left at posedge + 1)
    // ------------------------------------------------------------------
    task automatic send(input int i, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
        int n;
        n = 0;
        req_valid[i]  = 1'b1;
        req_we[i]     = we;
        funct3[i]     = f3;
        address[i]    = addr;
        write_data[i] = wd;
        while (1) begin
            @(posedge clk);
            #1;
            if (m_pend[i] && m_acc[i] == cyc) break;
            n++;
            if (n > 60) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout[%0d]: request not accepted within 60 cycles", i);
                break;
            end
        end
        req_valid[i] = 1'b0;
    endtask

    task automatic collect(input int i, output logic [31:0] d, output logic e, output int lat);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        d    = 32'h0;
        e    = 1'b0;
        lat  = -1;
        while (1) begin
            @(negedge clk);
            if (!seen && rsp_valid[i]) begin
                seen = 1'b1;
                lat  = n;
                d    = read_data[i];
                e    = err_o[i];
            end
            n++;
            @(posedge clk);
            #1;
            if (!m_pend[i]) break;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL response_timeout[%0d]: no completed response within 100 cycles", i);
                break;
            end
        end
    endtask

    // Directed transfer checked against literal expectations, which also
    // pins the model's own prediction.
    task automatic xchk(input string name, input int i, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e);
        logic [31:0] d;
        logic        e;
        int          lat;
        send(i, we, f3, addr, wd);
        collect(i, d, e, lat);
        chk({name, "_data"}, i, d, exp_d);
        chk({name, "_err"}, i, 32'(e), 32'(exp_e));
        chk({name, "_model"}, i, m_data[i], exp_d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;

        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            req_valid[i]  = 1'b0;
            req_we[i]     = 1'b0;
            funct3[i]     = 3'b000;
            address[i]    = 32'h0;
            write_data[i] = 32'h0;
            hold_low[i]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("reset_req_ready", i, 32'(req_ready[i]), 32'd1);
            chk("reset_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
            chk("reset_read_data", i, read_data[i], 32'h0);
            chk("reset_err", i, 32'(err_o[i]), 32'd0);
        end
        @(posedge clk);
        #1;

        // Known contents everywhere so every later load has a defined result
        for (int i = 0; i < NI; i++) begin
            for (int w = 0; w < DEPTH; w++) send(i, 1'b1, F_W, 32'(w * 4), fill_val(w));
            collect(i, d, e, lat);
        end

        // Store then load, latency 1
        xchk("t1_sw", 0, 1'b1, F_W, 32'h10, 32'h11223344, 32'h0, 1'b0);
        send(0, 1'b0, F_W, 32'h10, 32'h0);
        collect(0, d, e, lat);
        chk("t1_lw_data", 0, d, 32'h11223344);
        chk("t1_lw_err", 0, 32'(e), 32'd0);
        chk("t1_lw_latency", 0, 32'(lat), 32'd1);

        // Byte accesses
        xchk("t2_lb13",  0, 1'b0, F_B,  32'h13, 32'h0, 32'h00000044, 1'b0);
        xchk("t2_sb11",  0, 1'b1, F_B,  32'h11, 32'h000000F0, 32'h0, 1'b0);
        xchk("t2_lb11",  0, 1'b0, F_B,  32'h11, 32'h0, 32'hFFFFFFF0, 1'b0);
        xchk("t2_lbu11", 0, 1'b0, F_BU, 32'h11, 32'h0, 32'h000000F0, 1'b0);
        xchk("t2_lw10",  0, 1'b0, F_W,  32'h10, 32'h0, 32'h11F03344, 1'b0);

        // Halfword accesses and misalignment
        xchk("t3_sh20",  0, 1'b1, F_H,  32'h20, 32'h0000BEEF, 32'h0, 1'b0);
        xchk("t3_lh20",  0, 1'b0, F_H,  32'h20, 32'h0, 32'hFFFFBEEF, 1'b0);
        xchk("t3_lhu20", 0, 1'b0, F_HU, 32'h20, 32'h0, 32'h0000BEEF, 1'b0);
        xchk("t3_lh21",  0, 1'b0, F_H,  32'h21, 32'h0, 32'h0, 1'b1);
        xchk("t3_sh21",  0, 1'b1, F_H,  32'h21, 32'h00001234, 32'h0, 1'b1);
        xchk("t3_sw22",  0, 1'b1, F_W,  32'h22, 32'h12345678, 32'h0, 1'b1);
        xchk("t3_ill3",  0, 1'b1, 3'b011, 32'h20, 32'h12345678, 32'h0, 1'b1);
        xchk("t3_lw20",  0, 1'b0, F_W,  32'h20, 32'h0, 32'hBEEF5AC3, 1'b0);

        // Latency 3 with the consumer stalling
        hold_low[1] = 1'b1;
        send(1, 1'b0, F_W, 32'h10, 32'h0);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            chk("t4_rsp_valid", 1, 32'(rsp_valid[1]), 32'(k >= 3));
            chk("t4_req_ready", 1, 32'(req_ready[1]), 32'd0);
            if (k >= 3) chk("t4_read_data", 1, read_data[1], 32'h04FB5AC3);
        end
        @(posedge clk);
        #1 hold_low[1] = 1'b0;
        collect(1, d, e, lat);
        chk("t4_final_data", 1, d, 32'h04FB5AC3);

        // Reset during the wait of a load
        send(1, 1'b0, F_W, 32'h20, 32'h0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rsp_valid_low", 1, 32'(rsp_valid[1]), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_req_ready", 1, 32'(req_ready[1]), 32'd1);
        chk("t5_rsp_valid", 1, 32'(rsp_valid[1]), 32'd0);
        @(posedge clk);
        #1;
        xchk("t5_lw20", 1, 1'b0, F_W, 32'h20, 32'h0, 32'h08F75AC3, 1'b0);

        // Address beyond the byte space
        xchk("t6_sw_oob", 0, 1'b1, F_W, 32'(BYTES + 4), 32'hCAFEF00D, 32'h0, T6_ERR);
        xchk("t6_lw4",    0, 1'b0, F_W, 32'h4, 32'h0, T6_WORD, 1'b0);

        // Randomized traffic, back-to-back where possible
        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < 250; n++) begin
                we = 1'($urandom_range(0, 1));
                f3 = 3'($urandom_range(0, 7));
                if (we && (f3 == F_BU || f3 == F_HU)) f3 = F_W;
                if ($urandom_range(0, 9) == 0) addr = 32'($urandom_range(0, 4 * BYTES - 1));
                else                           addr = 32'($urandom_range(0, BYTES - 1));
                if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
                send(i, we, f3, addr, $urandom);
            end
            collect(i, d, e, lat);
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
